cla_pipe: RTL

//   Parametrised, pipelined carry-lookahead adder/subtractor; successor to the single-stage registered CLA.

---
 rtl/cla_pipe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Operands are split into STAGES segments. Each pipeline stage resolves one
// segment using 4-bit CLA blocks with block-level P/G lookahead. The carry
// is passed stage to stage, and skew registers keep each beat aligned.
module cla_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned NBLK = SEG / 4;

    // Adds one segment as a chain of 4-bit CLA blocks.
    // Block carries come from the block generate/propagate terms.
    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           cin
    );
        logic [SEG-1:0] sum;
        logic [3:0]     p;
        logic [3:0]     g;
        logic [3:0]     c_int;
        logic           bp;
        logic           bg;
        logic           c;
        sum = '0;
        c   = cin;
        for (int j = 0; j < int'(NBLK); j++) begin
            p        = x[j*4 +: 4] ^ y[j*4 +: 4];
            g        = x[j*4 +: 4] & y[j*4 +: 4];
            c_int[0] = c;
            c_int[1] = g[0] | (p[0] & c);
            c_int[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
            c_int[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
            bg       = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
            bp       = &p;
            sum[j*4 +: 4] = p ^ c_int;
            c        = bg | (bp & c);
        end
        return {c, sum};
    endfunction

    // Pipeline registers. Index 0 is the input register.
    // Index k holds the beat after segment k-1 has been resolved.
    logic             vld [0:STAGES];
    logic [WIDTH-1:0] opa [0:STAGES];
    logic [WIDTH-1:0] opb [0:STAGES];
    logic [WIDTH-1:0] res [0:STAGES];
    logic             cry [0:STAGES];

    logic [WIDTH-1:0] res_nx [1:STAGES];
    logic             cry_nx [1:STAGES];
    logic             stall;

    // A held result blocks the whole pipeline. Bubbles are kept, not collapsed.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Next partial result for each stage: insert the freshly added segment.
    always_comb begin
        logic [SEG:0] t;
        res_nx = '{default: '0};
        cry_nx = '{default: 1'b0};
        t      = '0;
        for (int k = 1; k <= int'(STAGES); k++) begin
            t = seg_add(opa[k-1][(k-1)*SEG +: SEG], opb[k-1][(k-1)*SEG +: SEG], cry[k-1]);
            res_nx[k] = res[k-1];
            res_nx[k][(k-1)*SEG +: SEG] = t[SEG-1:0];
            cry_nx[k] = t[SEG];
        end
    end

    // Advance the pipeline and the output register together whenever not stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= int'(STAGES); k++) begin
                vld[k] <= 1'b0;
                opa[k] <= '0;
                opb[k] <= '0;
                res[k] <= '0;
                cry[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (!stall) begin
            vld[0] <= in_valid;
            opa[0] <= a;
            opb[0] <= sub ? ~b : b;
            cry[0] <= sub | ci;
            res[0] <= '0;
            for (int k = 1; k <= int'(STAGES); k++) begin
                vld[k] <= vld[k-1];
                opa[k] <= opa[k-1];
                opb[k] <= opb[k-1];
                res[k] <= res_nx[k];
                cry[k] <= cry_nx[k];
            end
            out_valid <= vld[STAGES];
            // Keep the last result on the outputs while no new beat arrives.
            if (vld[STAGES]) begin
                s    <= res[STAGES];
                co   <= cry[STAGES];
                // The carry into the MSB is recovered as a^b'^s at that bit.
                ovf  <= opa[STAGES][WIDTH-1] ^ opb[STAGES][WIDTH-1]
                        ^ res[STAGES][WIDTH-1] ^ cry[STAGES];
                zero <= (res[STAGES] == '0);
            end
        end
    end

endmodule
